// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 1-to-8 TDM demultiplexer with frame-sync tracking
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data / in_sync qualified this cycle
//   in_data    incoming word (WIDTH bits)
//   in_sync    marks in_data as slot 0 of a frame (ignored when in_valid=0)
//   out_bus    channel k held at out_bus[k*WIDTH +: WIDTH]
//   out_valid  one-cycle strobe, bit k set when channel k was written
//   frame_done one-cycle pulse when slot 7 is written
//   sync_err   one-cycle pulse on early or missing sync
//   locked     frame alignment held
module tdm_demux8 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sync,
    output logic [8*WIDTH-1:0] out_bus,
    output logic [7:0]         out_valid,
    output logic               frame_done,
    output logic               sync_err,
    output logic               locked
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] slot;   // slot the next accepted word is expected to occupy

    always_ff @(posedge clk) begin
        // Strobes are single-cycle: cleared every cycle, set below when needed.
        out_valid  <= '0;
        frame_done <= 1'b0;
        sync_err   <= 1'b0;

        if (rst) begin
            state   <= HUNT;
            slot    <= 3'd0;
            out_bus <= '0;
            locked  <= 1'b0;
        end else if (in_valid) begin
            case (state)
                HUNT: begin
                    // Words are discarded until a sync marker establishes slot 0.
                    if (in_sync) begin
                        out_bus[0 +: WIDTH] <= in_data;
                        out_valid[0]        <= 1'b1;
                        slot                <= 3'd1;
                        state               <= LOCKED;
                        locked              <= 1'b1;
                    end
                end

                LOCKED: begin
                    if (in_sync) begin
                        // A sync always realigns to slot 0; arriving anywhere
                        // other than slot 0 truncates the frame and is an error.
                        out_bus[0 +: WIDTH] <= in_data;
                        out_valid[0]        <= 1'b1;
                        slot                <= 3'd1;
                        if (slot != 3'd0) begin
                            sync_err <= 1'b1;
                        end
                    end else if (slot == 3'd0) begin
                        // Frame boundary without a sync marker: alignment lost.
                        sync_err <= 1'b1;
                        state    <= HUNT;
                        locked   <= 1'b0;
                    end else begin
                        out_bus[int'(slot)*WIDTH +: WIDTH] <= in_data;
                        out_valid[slot]                    <= 1'b1;
                        if (slot == 3'd7) begin
                            frame_done <= 1'b1;
                        end
                        slot <= slot + 3'd1;   // wraps 7 -> 0
                    end
                end

                default: begin
                    state  <= HUNT;
                    slot   <= 3'd0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
